// File: rtl/float_result_stage_if.sv
// Handshake bundle between the adder, the result stage and the downstream consumer.
// The slave modport is the stage's view. The master modport is the view of the surrounding logic.
interface float_result_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_a, in_b, in_result, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_result, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/float_result_stage.sv
// Registered output stage for the single-precision adder. It canonicalises NaNs, classifies each result,
// keeps sticky exception flags and a result count, and drives the results out through a 2-entry skid buffer.
module float_result_stage #(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  float_result_stage_if.slave  bus,
  input  logic                 flags_clr,
  output logic [2:0]           sticky_flags,
  output logic [COUNT_W-1:0]   result_count
);

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;   // {nv, of, uf, zero}
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{result: 32'h0000_0000, flags: 4'h0};

  function automatic logic exp_all_ones(input logic [31:0] v);
    return v[30:23] == 8'hFF;
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return exp_all_ones(v) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return exp_all_ones(v) && (v[22:0] == 23'd0);
  endfunction

  // A quiet-bit of zero on a NaN marks it as signalling.
  function automatic logic is_snan(input logic [31:0] v);
    return is_nan(v) && !v[22];
  endfunction

  logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s;
  logic        inf_clash_s, force_nan_s;
  logic        nv_s, of_s, uf_s, zero_s;
  logic [31:0] fixed_s;
  entry_t      new_entry_s;

  logic        accept_s, pop_s;
  logic        out_valid_r, out_valid_nxt_s;
  entry_t      out_entry_r, out_entry_nxt_s;
  logic        skid_valid_r, skid_valid_nxt_s;
  entry_t      skid_entry_r, skid_entry_nxt_s;
  logic        in_ready_r;
  logic [2:0]  sticky_r, sticky_nxt_s, new_bits_s;
  logic [COUNT_W-1:0] count_r, count_nxt_s;

  // Classify the operands and the raw result, and build the corrected entry.
  always_comb begin
    nan_a_s     = is_nan(bus.in_a);
    nan_b_s     = is_nan(bus.in_b);
    inf_a_s     = is_inf(bus.in_a);
    inf_b_s     = is_inf(bus.in_b);
    inf_clash_s = inf_a_s && inf_b_s && (bus.in_a[31] != bus.in_b[31]);
    nv_s        = is_snan(bus.in_a) || is_snan(bus.in_b) || inf_clash_s;
    force_nan_s = nan_a_s || nan_b_s || inf_clash_s || is_nan(bus.in_result);
    if (force_nan_s) begin
      fixed_s = CANON_NAN;
    end else begin
      fixed_s = bus.in_result;
    end
    // Overflow means the adder itself produced infinity from finite operands.
    of_s   = !force_nan_s && exp_all_ones(bus.in_result) && !inf_a_s && !inf_b_s;
    uf_s   = (fixed_s[30:23] == 8'h00) && (fixed_s[22:0] != 23'd0);
    zero_s = (fixed_s[30:0] == 31'd0);
    new_entry_s.result = fixed_s;
    new_entry_s.flags  = {nv_s, of_s, uf_s, zero_s};
  end

  assign accept_s = bus.in_valid && in_ready_r;
  assign pop_s    = out_valid_r && bus.out_ready;

  // Compute the next state of the skid buffer. The skid register fills only when the output register is blocked.
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_entry_nxt_s  = out_entry_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_entry_nxt_s = skid_entry_r;
    if (skid_valid_r) begin
      if (pop_s) begin
        out_entry_nxt_s  = skid_entry_r;
        skid_valid_nxt_s = 1'b0;
      end else begin
        skid_valid_nxt_s = 1'b1;
      end
    end else if (accept_s) begin
      if (!out_valid_r || bus.out_ready) begin
        out_entry_nxt_s = new_entry_s;
        out_valid_nxt_s = 1'b1;
      end else begin
        skid_entry_nxt_s = new_entry_s;
        skid_valid_nxt_s = 1'b1;
      end
    end else if (pop_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Compute the next sticky flags and result count. A flag set by the accepted entry survives a coincident clear.
  always_comb begin
    if (accept_s) begin
      new_bits_s  = {nv_s, of_s, uf_s};
      count_nxt_s = count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      new_bits_s  = 3'b000;
      count_nxt_s = count_r;
    end
    if (flags_clr) begin
      sticky_nxt_s = new_bits_s;
    end else begin
      sticky_nxt_s = sticky_r | new_bits_s;
    end
  end

  // Update all state registers. Reset clears both buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_entry_r  <= ENTRY_ZERO;
      skid_valid_r <= 1'b0;
      skid_entry_r <= ENTRY_ZERO;
      in_ready_r   <= 1'b1;
      sticky_r     <= 3'b000;
      count_r      <= {COUNT_W{1'b0}};
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      out_entry_r  <= out_entry_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_entry_r <= skid_entry_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
      sticky_r     <= sticky_nxt_s;
      count_r      <= count_nxt_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_entry_r.result;
  assign bus.out_flags  = out_entry_r.flags;
  assign sticky_flags   = sticky_r;
  assign result_count   = count_r;

endmodule
